// File: rtl/bounce_pkg.sv
// rtl/bounce_pkg.sv - shared types, colour advance and reset-value helpers for the bounce engine
package bounce_pkg;

    typedef logic [2:0] colour_t;

    typedef enum logic {
        S_IDLE,
        S_UPDATE
    } state_t;

    // Colour cycles 1..7 and never lands on 0 (0 would be indistinguishable from black).
    function automatic colour_t colour_advance(input colour_t c);
        return (c == 3'd7) ? 3'd1 : c + 3'd1;
    endfunction

    function automatic int init_x(input int i, input int span);
        return (50 + 137 * i) % span;
    endfunction

    function automatic int init_y(input int i, input int span);
        return (50 + 71 * i) % span;
    endfunction

    function automatic int init_xv(input int i);
        return (i % 2 == 0) ? 2 : -2;
    endfunction

    function automatic colour_t init_colour(input int i);
        return colour_t'((i % 7) + 1);
    endfunction

endpackage

// File: rtl/bounce_axis_step.sv
// rtl/bounce_axis_step.sv - one-axis position/velocity step with wall bounce
module bounce_axis_step #(
    parameter int SCREEN = 640,
    parameter int BOX    = 100,
    parameter int VEL_W  = 4,
    parameter int PW     = $clog2(SCREEN)
) (
    input  logic        [PW-1:0]    pos_i,
    input  logic signed [VEL_W-1:0] vel_i,
    output logic        [PW-1:0]    pos_next_o,
    output logic signed [VEL_W-1:0] vel_next_o,
    output logic                    hit_o
);

    localparam int TW    = PW + 2;
    localparam int LIMIT = SCREEN - BOX;

    // Two extra bits keep the trajectory signed and free of overflow at both walls.
    logic signed [TW-1:0] traj;
    logic signed [TW-1:0] lim;

    assign traj = $signed({2'b00, pos_i}) + $signed({{(TW-VEL_W){vel_i[VEL_W-1]}}, vel_i});
    assign lim  = TW'(LIMIT);

    always_comb begin
        pos_next_o = traj[PW-1:0];
        vel_next_o = vel_i;
        hit_o      = 1'b0;
        if (vel_i < 0 && traj <= 0) begin
            pos_next_o = '0;
            vel_next_o = -vel_i;
            hit_o      = 1'b1;
        end else if (vel_i > 0 && traj >= lim) begin
            pos_next_o = PW'(LIMIT);
            vel_next_o = -vel_i;
            hit_o      = 1'b1;
        end
    end

endmodule

// File: rtl/bounce_engine.sv
// rtl/bounce_engine.sv - bouncing-box state updater and pixel compositor
module bounce_engine
    import bounce_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int BOX_W    = 100,
    parameter int BOX_H    = 100,
    parameter int N_BOXES  = 4,
    parameter int VEL_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_tick,
    input  logic                        visible,
    input  logic [$clog2(SCREEN_W)-1:0] pos_x,
    input  logic [$clog2(SCREEN_H)-1:0] pos_y,
    output logic [3:0]                  r,
    output logic [3:0]                  g,
    output logic [3:0]                  b,
    output logic                        busy
);

    localparam int XW = $clog2(SCREEN_W);
    localparam int YW = $clog2(SCREEN_H);
    localparam int IW = (N_BOXES > 1) ? $clog2(N_BOXES) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_BOXES - 1);

    logic        [XW-1:0]    x_q   [N_BOXES];
    logic        [YW-1:0]    y_q   [N_BOXES];
    logic signed [VEL_W-1:0] xv_q  [N_BOXES];
    logic signed [VEL_W-1:0] yv_q  [N_BOXES];
    colour_t                 col_q [N_BOXES];

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic            pending_q;
    logic            busy_q;
    logic [3:0]      r_q, g_q, b_q;

    logic        [XW-1:0]    x_d;
    logic        [YW-1:0]    y_d;
    logic signed [VEL_W-1:0] xv_d, yv_d;
    logic                    x_hit, y_hit;

    bounce_axis_step #(.SCREEN(SCREEN_W), .BOX(BOX_W), .VEL_W(VEL_W)) u_step_x (
        .pos_i(x_q[idx_q]), .vel_i(xv_q[idx_q]),
        .pos_next_o(x_d), .vel_next_o(xv_d), .hit_o(x_hit)
    );

    bounce_axis_step #(.SCREEN(SCREEN_H), .BOX(BOX_H), .VEL_W(VEL_W)) u_step_y (
        .pos_i(y_q[idx_q]), .vel_i(yv_q[idx_q]),
        .pos_next_o(y_d), .vel_next_o(yv_d), .hit_o(y_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < N_BOXES; i++) begin
                x_q[i]   <= XW'(init_x(i, SCREEN_W - BOX_W));
                y_q[i]   <= YW'(init_y(i, SCREEN_H - BOX_H));
                xv_q[i]  <= VEL_W'(init_xv(i));
                yv_q[i]  <= VEL_W'(1);
                col_q[i] <= init_colour(i);
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (frame_tick) begin
                        state_q <= S_UPDATE;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                    end
                end
                S_UPDATE: begin
                    x_q[idx_q]  <= x_d;
                    y_q[idx_q]  <= y_d;
                    xv_q[idx_q] <= xv_d;
                    yv_q[idx_q] <= yv_d;
                    if (x_hit || y_hit) col_q[idx_q] <= colour_advance(col_q[idx_q]);
                    if (idx_q == LAST) begin
                        idx_q <= '0;
                        // A tick landing on the final slot still counts as pending.
                        if (pending_q || frame_tick) begin
                            pending_q <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        idx_q <= idx_q + IW'(1);
                        if (frame_tick) pending_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    logic    hit_any;
    colour_t hit_col;

    // Scan high to low so the lowest-index covering box is the last one written.
    always_comb begin
        hit_any = 1'b0;
        hit_col = '0;
        for (int i = N_BOXES - 1; i >= 0; i--) begin
            if ({1'b0, pos_x} >= {1'b0, x_q[i]} && {1'b0, pos_x} < {1'b0, x_q[i]} + (XW+1)'(BOX_W) &&
                {1'b0, pos_y} >= {1'b0, y_q[i]} && {1'b0, pos_y} < {1'b0, y_q[i]} + (YW+1)'(BOX_H)) begin
                hit_any = 1'b1;
                hit_col = col_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !visible) begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
        end else if (hit_any) begin
            r_q <= {4{hit_col[0]}};
            g_q <= {4{hit_col[1]}};
            b_q <= {4{hit_col[2]}};
        end else begin
            r_q <= 4'h1;
            g_q <= 4'h1;
            b_q <= 4'h1;
        end
    end

    assign r    = r_q;
    assign g    = g_q;
    assign b    = b_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_bounce_engine.sv
// tb/tb_bounce_engine.sv - self-checking bench for bounce_engine
module tb_bounce_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       visible = 1'b0;
    logic [9:0] pos_x = '0;
    logic [8:0] pos_y = '0;
    logic [3:0] r, g, b;
    logic       busy;

    int checks = 0;
    int errors = 0;

    bounce_engine dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .visible(visible),
        .pos_x(pos_x), .pos_y(pos_y), .r(r), .g(g), .b(b), .busy(busy)
    );

    always #5 clk = ~clk;

    int mx[4], my[4], mxv[4], myv[4], mc[4];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mx[i] = (50 + 137 * i) % 540;
            my[i] = (50 + 71 * i) % 380;
            mxv[i] = (i % 2 == 0) ? 2 : -2;
            myv[i] = 1;
            mc[i] = (i % 7) + 1;
        end
    endtask

    task automatic axis(inout int p, inout int v, input int lim, output bit hit);
        int t;
        t = p + v;
        hit = 1'b0;
        if (v < 0 && t <= 0) begin p = 0; v = -v; hit = 1'b1; end
        else if (v > 0 && t >= lim) begin p = lim; v = -v; hit = 1'b1; end
        else p = t;
    endtask

    task automatic model_pass();
        bit hx, hy;
        for (int i = 0; i < 4; i++) begin
            axis(mx[i], mxv[i], 540, hx);
            axis(my[i], myv[i], 380, hy);
            if (hx || hy) mc[i] = (mc[i] == 7) ? 1 : mc[i] + 1;
        end
    endtask

    function automatic logic [11:0] exp_pix(input logic v, input int px, input int py);
        if (!v) return 12'h000;
        for (int i = 0; i < 4; i++)
            if (px >= mx[i] && px < mx[i] + 100 && py >= my[i] && py < my[i] + 100)
                return {{4{mc[i][0]}}, {4{mc[i][1]}}, {4{mc[i][2]}}};
        return 12'h111;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic probe(input string nm, input logic v, input int px, input int py, input logic [11:0] expv);
        visible = v;
        pos_x = px[9:0];
        pos_y = py[8:0];
        @(negedge clk);
        check(nm, {20'b0, r, g, b}, {20'b0, expv});
        visible = 1'b0;
    endtask

    task automatic probe_model(input int px, input int py);
        probe("pix_model", 1'b1, px, py, exp_pix(1'b1, px, py));
    endtask

    // Issues one tick (plus two during UPDATE if extra) and counts contiguous busy cycles.
    task automatic run_pass(input bit extra, output int cnt);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) cnt++;
            else if (cnt > 0) break;
            frame_tick = (extra && (k == 1 || k == 2));
            @(negedge clk);
        end
        frame_tick = 1'b0;
    endtask

    typedef struct {
        logic        vis;
        int          px;
        int          py;
        logic [11:0] expv;
    } vec_t;

    vec_t vecs[12];

    task automatic run_reset_table();
        for (int i = 0; i < 12; i++)
            probe($sformatf("reset_vec%0d", i), vecs[i].vis, vecs[i].px, vecs[i].py, vecs[i].expv);
    endtask

    initial begin
        int cnt;
        bit ext;
        vecs[0]  = '{1'b1,  50,  50, 12'hF00};
        vecs[1]  = '{1'b1,  49,  50, 12'h111};
        vecs[2]  = '{1'b1, 150,  50, 12'h111};
        vecs[3]  = '{1'b1, 187, 121, 12'h0F0};
        vecs[4]  = '{1'b1, 186, 121, 12'h111};
        vecs[5]  = '{1'b1, 324, 192, 12'hFF0};
        vecs[6]  = '{1'b1, 461, 263, 12'h00F};
        vecs[7]  = '{1'b1, 423, 291, 12'hFF0};
        vecs[8]  = '{1'b1, 424, 291, 12'h111};
        vecs[9]  = '{1'b0,  50,  50, 12'h000};
        vecs[10] = '{1'b1, 149, 149, 12'hF00};
        vecs[11] = '{1'b1, 560, 362, 12'h00F};

        model_reset();
        repeat (3) @(negedge clk);
        check("reset_rgb_in_rst", {20'b0, r, g, b}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_rgb", {20'b0, r, g, b}, 32'h0);
        run_reset_table();

        run_pass(1'b0, cnt);
        check("single_pass_busy_cycles", cnt, 4);
        model_pass();
        probe("box0_moved_in", 1'b1, 52, 51, 12'hF00);
        probe("box0_moved_left_edge", 1'b1, 51, 51, 12'h111);

        run_pass(1'b1, cnt);
        check("pending_busy_cycles", cnt, 8);
        model_pass();
        model_pass();
        for (int i = 0; i < 4; i++) probe_model(mx[i], my[i]);

        for (int f = 0; f < 380; f++) begin
            ext = ($urandom_range(0, 9) == 0);
            run_pass(ext, cnt);
            check("frame_busy_cycles", cnt, ext ? 8 : 4);
            model_pass();
            if (ext) model_pass();
            for (int i = 0; i < 4; i++) begin
                probe_model(mx[i], my[i]);
                probe_model((mx[i] > 0) ? mx[i] - 1 : 0, my[i]);
                probe_model(mx[i] + 99, my[i] + 99);
                probe_model(mx[i] + 100, (my[i] > 0) ? my[i] - 1 : 0);
            end
            probe_model($urandom_range(0, 639), $urandom_range(0, 479));
            probe("pix_invisible", 1'b0, $urandom_range(0, 639), $urandom_range(0, 479), 12'h000);
        end

        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_before_abort", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("abort_busy", {31'b0, busy}, 32'h0);
        repeat (6) @(negedge clk);
        check("abort_stays_idle", {31'b0, busy}, 32'h0);
        run_reset_table();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
